// File: rtl/debounce_toggle_gen.sv
// Push-button debouncer: two-flop synchronizer, four-state qualification FSM,
// and a single-cycle toggle pulse on accepted press (and optionally release).
module debounce_toggle_gen #(
  parameter int DEB_CYCLES       = 4,
  parameter int CNT_W            = 3,
  parameter bit PULSE_ON_RELEASE = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_in,
  output logic t_out,
  output logic btn_level,
  output logic busy
);

  typedef enum logic [1:0] {IDLE_LO, QUAL_HI, IDLE_HI, QUAL_LO} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             t_out_q, t_out_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;

  always_comb begin
    s1_d    = btn_in;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    t_out_d = 1'b0;
    level_d = level_q;
    case (state_q)
      IDLE_LO: begin
        if (s2_q) begin
          state_d = QUAL_HI;
          cnt_d   = '0;
        end
      end
      QUAL_HI: begin
        if (!s2_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          level_d = 1'b1;
          t_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!s2_q) begin
          state_d = QUAL_LO;
          cnt_d   = '0;
        end
      end
      QUAL_LO: begin
        // An opposite sample aborts; the level is left untouched on abort.
        if (s2_q) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          level_d = 1'b0;
          t_out_d = PULSE_ON_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == QUAL_HI) || (state_d == QUAL_LO);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      t_out_q <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_out_q <= t_out_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign t_out     = t_out_q;
  assign btn_level = level_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_debounce_toggle_gen.sv
// Bench for debounce_toggle_gen: directed press/bounce/release/reset scenarios
// plus random button noise, checked against a run-length reference model.
module tb_debounce_toggle_gen;

  localparam int DEB = 4;

  logic clk;
  logic rstn;
  logic btn_in;
  logic t0, l0, b0;
  logic t1, l1, b1;
  logic tq;

  int checks;
  int fails;
  int sec_pulses;
  logic prev_t0, prev_t1;

  // Reference model state: sync pipeline, debounced level, run length of disagreeing samples
  logic m_s1, m_s2, m_level;
  int   m_run;
  logic e_t0, e_t1, e_busy;

  debounce_toggle_gen #(.DEB_CYCLES(DEB), .CNT_W(3), .PULSE_ON_RELEASE(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .btn_in(btn_in),
    .t_out(t0), .btn_level(l0), .busy(b0)
  );

  debounce_toggle_gen #(.DEB_CYCLES(DEB), .CNT_W(3), .PULSE_ON_RELEASE(1'b1)) dut1 (
    .clk(clk), .rstn(rstn), .btn_in(btn_in),
    .t_out(t1), .btn_level(l1), .busy(b1)
  );

  // Downstream toggle flip-flop fed by the press-only instance
  always_ff @(posedge clk) begin
    if (!rstn) tq <= 1'b0;
    else if (t0) tq <= ~tq;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input logic b, input logic r);
    logic seen;
    e_t0 = 1'b0;
    e_t1 = 1'b0;
    if (!r) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_run = 0;
    end else begin
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = b;
      if (seen != m_level) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_level = seen;
          m_run   = 0;
          e_t0    = seen;
          e_t1    = 1'b1;
        end
      end else begin
        m_run = 0;
      end
    end
    e_busy = (m_run != 0);
  endtask

  task automatic apply_stimulus(input logic b, input logic r);
    btn_in = b;
    rstn   = r;
    @(posedge clk);
    model_update(b, r);
    #1;
    check_output("t_out_p0", t0, e_t0);
    check_output("level_p0", l0, m_level);
    check_output("busy_p0", b0, e_busy);
    check_output("t_out_p1", t1, e_t1);
    check_output("level_p1", l1, m_level);
    check_output("busy_p1", b1, e_busy);
    check_output("no_back_to_back", (t0 & prev_t0) | (t1 & prev_t1), 1'b0);
    prev_t0 = t0;
    prev_t1 = t1;
    if (t0) sec_pulses++;
  endtask

  initial begin
    checks = 0; fails = 0; sec_pulses = 0;
    prev_t0 = 1'b0; prev_t1 = 1'b0;
    m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_run = 0;
    e_t0 = 1'b0; e_t1 = 1'b0; e_busy = 1'b0;
    btn_in = 1'b0;
    rstn   = 1'b0;

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0);
    check_output("reset_t_out", t0, 1'b0);
    check_output("reset_level", l0, 1'b0);
    check_output("reset_busy", b0, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1);

    $display("[TB] clean press");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 1'b1);
      check_output("press_pulse", t0, i == 6);
      check_output("press_level", l0, i >= 6);
      check_output("press_busy", b0, (i >= 2) && (i <= 5));
    end

    $display("[TB] release");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b1);
      check_output("release_level", l0, i < 6);
      check_output("release_no_pulse", t0, 1'b0);
      check_output("release_pulse_p1", t1, i == 6);
    end

    $display("[TB] bounce");
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(i != 2, 1'b1);
      check_output("bounce_pulse", t0, i == 9);
      check_output("bounce_level", l0, i >= 9);
    end
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1);

    $display("[TB] reset mid-qualification");
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b1);
    check_output("midqual_busy", b0, 1'b1);
    apply_stimulus(1'b1, 1'b0);
    check_output("midqual_rst_t_out", t0, 1'b0);
    check_output("midqual_rst_level", l0, 1'b0);
    check_output("midqual_rst_busy", b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 1'b1);
      check_output("post_reset_pulse", t0, i == 6);
    end
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1);

    $display("[TB] chained toggle");
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    check_output("toggle_q0", tq, 1'b0);
    sec_pulses = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 1'b1);
      check_output("toggle_q", tq, (p % 2) == 0);
      for (int i = 0; i < 9; i++) apply_stimulus(1'b0, 1'b1);
    end
    check_output("toggle_pulse_count", sec_pulses == 3, 1'b1);

    $display("[TB] random noise");
    for (int i = 0; i < 600; i++) begin
      logic b;
      logic r;
      b = btn_in;
      if (((i / 40) % 2) == 0) begin
        if ($urandom_range(1) == 0) b = ~b;
      end else begin
        if ($urandom_range(11) == 0) b = ~b;
      end
      r = ($urandom_range(79) != 0);
      apply_stimulus(b, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/debounce_toggle_gen.md
DEBOUNCE_TOGGLE_GEN -- requirements
Module: debounce_toggle_gen

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable synchronized samples required to accept a level change; legal range >= 2.
REQ-002 Parameter CNT_W, default 3: debounce counter width; SHALL satisfy 2^CNT_W >= DEB_CYCLES.
REQ-003 Parameter PULSE_ON_RELEASE, default 0: 0 = pulse on accepted press only; 1 = pulse on accepted press and on accepted release.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port rstn, input, 1: reset, synchronous, active-low, sampled on rising edge of clk.
REQ-006 Port btn_in, input, 1: raw asynchronous, possibly bouncing, push-button level.
REQ-007 Port t_out, output, 1: registered single-cycle toggle pulse that drives the T input of the downstream toggle flip-flop.
REQ-008 Port btn_level, output, 1: registered debounced button level.
REQ-009 Port busy, output, 1: registered; 1 while a debounce qualification is in progress.

Function
REQ-010 btn_in SHALL pass through a two-flop synchronizer (s1, s2); the FSM and counter SHALL observe only s2.
REQ-011 The FSM SHALL have exactly four states: IDLE_LO, QUAL_HI, IDLE_HI, QUAL_LO.
REQ-012 In IDLE_LO with s2=1, the FSM SHALL go to QUAL_HI and load cnt=0; with s2=0, it SHALL stay.
REQ-013 In QUAL_HI with s2=0, the FSM SHALL return to IDLE_LO and emit no pulse (glitch rejected).
REQ-014 In QUAL_HI with s2=1 and cnt<DEB_CYCLES-1, it SHALL increment cnt by 1.
REQ-015 In QUAL_HI with s2=1 and cnt==DEB_CYCLES-1, it SHALL go to IDLE_HI, set btn_level=1, and set t_out=1 for exactly one cycle.
REQ-016 IDLE_HI and QUAL_LO SHALL mirror REQ-012..REQ-015 with polarity inverted.
REQ-017 On acceptance in QUAL_LO, the block SHALL set btn_level=0; t_out SHALL be 1 for one cycle only if PULSE_ON_RELEASE=1.
REQ-018 t_out SHALL be 0 in every cycle other than an acceptance cycle; the block SHALL never assert it two cycles in a row.
REQ-019 Latency: with btn_in stable from before sampling edge E0, t_out and btn_level SHALL change after edge E0+DEB_CYCLES+2 (E6 for DEB_CYCLES=4).
REQ-020 busy SHALL be 1 exactly while in QUAL_HI or QUAL_LO.
REQ-021 cnt SHALL never exceed DEB_CYCLES-1 and SHALL never wrap.
REQ-022 Any opposite-level s2 sample during qualification SHALL abort it; the next qualification SHALL restart from cnt=0.
REQ-023 btn_level SHALL change only at acceptance; it SHALL never change in the same cycle as an abort.

Reset
REQ-024 While rstn=0 at a clock edge, the block SHALL clear s1, s2, cnt, t_out, btn_level, and busy to 0 and set the state to IDLE_LO.
REQ-025 A reset during qualification SHALL discard it with no pulse emitted.
REQ-026 If btn_in is held high across reset release, the block SHALL run a full new qualification and emit one t_out pulse DEB_CYCLES+2 edges after the first edge with rstn=1.
REQ-027 No output SHALL change asynchronously to clk.

Verification
REQ-028 Clean press, DEB_CYCLES=4: btn_in 0->1 held -> one-cycle t_out after edge E6; btn_level=1 from the same cycle; busy high for 4 cycles.
REQ-029 Bounce: btn_in high 2 cycles, low 1 cycle, then held high -> no pulse during the bounce; exactly one t_out, 6 edges after the final rising edge.
REQ-030 Release, PULSE_ON_RELEASE=0 then 1: btn_in 1->0 held -> btn_level=0 after E6; t_out stays 0 (case 0) or pulses once (case 1).
REQ-031 Reset mid-qualification: rstn=0 while cnt=2 -> all outputs 0 next edge; after release with btn_in still high, one pulse 6 edges later.
REQ-032 Chained toggle: 3 clean presses feeding the downstream toggle flip-flop -> exactly 3 t_out pulses; downstream q sequence 0->1->0->1.
